ss_readback: RTL and testbench

- Passive decoder at the far end of the multiplexed seven-segment bus produced by SS_Driver (SegmentDrivers / SevenSegment).
- Samples the anode and cathode lines and rebuilds the four BCD time digits (hours2, hours1, mins2, mins1) from the scanned patterns.
- Used on-chip as a self-check and readback path for the wallclock, and as the bench-side monitor for display tests.
- Ignores PWM blanking phases, scan transitions and ghosting. Flags undecodable patterns and out-of-range times.

---
 rtl/ss_readback.sv | 194 +++++++++++++++++++
 tb/tb_ss_readback.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ss_readback.sv
// Passive readback of the multiplexed seven-segment bus: rebuilds the four BCD
// time digits from the scanned anode/cathode patterns and flags bad frames.
module ss_readback #(
   parameter int unsigned STABLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 4000000
) (
   input  logic       CLK100MHZ,
   input  logic       ResetButton,
   input  logic [7:0] SegmentDrivers,
   input  logic [7:0] SevenSegment,
   output logic [3:0] hours2,
   output logic [3:0] hours1,
   output logic [3:0] mins2,
   output logic [3:0] mins1,
   output logic       frame_valid,
   output logic       decode_error,
   output logic       range_error,
   output logic       display_alive
);

   // state      | meaning
   // ST_COLLECT | gathering digit captures into the shadow set
   // ST_PUBLISH | shadow was copied to the outputs on entry; frame_valid high
   typedef enum logic {ST_COLLECT = 1'b0, ST_PUBLISH = 1'b1} state_t;

   localparam logic [7:0]  STABLE_LIM  = 8'(STABLE_CYCLES);
   localparam logic [23:0] TIMEOUT_LIM = 24'(TIMEOUT_CYCLES);

   state_t      state_q, state_nxt;
   logic [7:0]  anode_q;
   logic [6:0]  seg_q;
   logic [10:0] key_prev_q;
   logic [10:0] key_cur;
   logic [7:0]  stab_cnt_q, stab_cnt_nxt;
   logic [23:0] tmo_cnt_q, tmo_cnt_nxt;
   logic [3:0]  seen_q, seen_nxt;
   logic [3:0]  shadow_q [4];
   logic [3:0]  anode_lo;
   logic        one_hot;
   logic        sample_legal;
   logic        capture;
   logic        cap_ok;
   logic [1:0]  cap_idx;
   logic [3:0]  cap_digit;
   logic        cap_valid;
   logic        timeout_evt;
   logic        load_frame;
   logic        dp_unused;

   assign dp_unused = SevenSegment[7];

   always_ff @(posedge CLK100MHZ) begin
      if (ResetButton) begin
         anode_q <= 8'h00;
         seg_q   <= 7'h00;
      end else begin
         anode_q <= SegmentDrivers;
         seg_q   <= SevenSegment[6:0];
      end
   end

   assign anode_lo     = ~anode_q[3:0];
   assign one_hot      = (anode_lo != 4'h0) && ((anode_lo & (anode_lo - 4'h1)) == 4'h0);
   assign sample_legal = (anode_q[7:4] == 4'hF) && one_hot && (seg_q != 7'h7F);
   assign key_cur      = {anode_q[3:0], seg_q};

   always_comb begin
      stab_cnt_nxt = 8'h00;
      if (sample_legal) begin
         if (key_cur == key_prev_q)
            stab_cnt_nxt = (stab_cnt_q >= STABLE_LIM) ? STABLE_LIM : stab_cnt_q + 8'h01;
         else
            stab_cnt_nxt = 8'h01;
      end
   end

   // Capture only on the edge the counter first reaches the limit, so a long
   // dwell produces a single capture.
   assign capture = sample_legal && (stab_cnt_nxt == STABLE_LIM) && (stab_cnt_q != STABLE_LIM);

   always_comb begin
      cap_idx = 2'd0;
      unique casez (anode_lo)
         4'b???1: cap_idx = 2'd0;
         4'b??10: cap_idx = 2'd1;
         4'b?100: cap_idx = 2'd2;
         4'b1000: cap_idx = 2'd3;
         default: cap_idx = 2'd0;
      endcase
   end

   always_comb begin
      cap_valid = 1'b1;
      cap_digit = 4'd0;
      case (seg_q)
         7'h40:   cap_digit = 4'd0;
         7'h79:   cap_digit = 4'd1;
         7'h24:   cap_digit = 4'd2;
         7'h30:   cap_digit = 4'd3;
         7'h19:   cap_digit = 4'd4;
         7'h12:   cap_digit = 4'd5;
         7'h02:   cap_digit = 4'd6;
         7'h78:   cap_digit = 4'd7;
         7'h00:   cap_digit = 4'd8;
         7'h10:   cap_digit = 4'd9;
         default: cap_valid = 1'b0;
      endcase
   end

   assign cap_ok = capture && cap_valid;

   always_comb begin
      tmo_cnt_nxt = tmo_cnt_q;
      if (cap_ok)
         tmo_cnt_nxt = 24'h0;
      else if (tmo_cnt_q != TIMEOUT_LIM)
         tmo_cnt_nxt = tmo_cnt_q + 24'h1;
   end

   // A capture on the same edge as the timeout wins.
   assign timeout_evt = !cap_ok && (tmo_cnt_nxt == TIMEOUT_LIM);

   always_ff @(posedge CLK100MHZ) begin
      if (ResetButton)
         state_q <= ST_COLLECT;
      else
         state_q <= state_nxt;
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_COLLECT: if (seen_q == 4'hF) state_nxt = ST_PUBLISH;
         ST_PUBLISH: state_nxt = ST_COLLECT;
         default:    state_nxt = ST_COLLECT;
      endcase
   end

   always_comb begin
      load_frame  = (state_q == ST_COLLECT) && (seen_q == 4'hF);
      frame_valid = (state_q == ST_PUBLISH);
   end

   always_comb begin
      seen_nxt = load_frame ? 4'h0 : seen_q;
      if (cap_ok)
         seen_nxt = seen_nxt | (4'b0001 << cap_idx);
      else if (timeout_evt)
         seen_nxt = 4'h0;
   end

   always_ff @(posedge CLK100MHZ) begin
      if (ResetButton) begin
         key_prev_q    <= 11'h0;
         stab_cnt_q    <= 8'h00;
         tmo_cnt_q     <= 24'h0;
         seen_q        <= 4'h0;
         display_alive <= 1'b0;
         decode_error  <= 1'b0;
         for (int i = 0; i < 4; i++) shadow_q[i] <= 4'h0;
      end else begin
         key_prev_q   <= key_cur;
         stab_cnt_q   <= stab_cnt_nxt;
         tmo_cnt_q    <= tmo_cnt_nxt;
         seen_q       <= seen_nxt;
         decode_error <= capture && !cap_valid;
         if (cap_ok) begin
            shadow_q[cap_idx] <= cap_digit;
            display_alive     <= 1'b1;
         end else if (timeout_evt) begin
            display_alive <= 1'b0;
         end
      end
   end

   always_ff @(posedge CLK100MHZ) begin
      if (ResetButton) begin
         hours2      <= 4'h0;
         hours1      <= 4'h0;
         mins2       <= 4'h0;
         mins1       <= 4'h0;
         range_error <= 1'b0;
      end else if (load_frame) begin
         hours2      <= shadow_q[3];
         hours1      <= shadow_q[2];
         mins2       <= shadow_q[1];
         mins1       <= shadow_q[0];
         range_error <= (shadow_q[3] > 4'd2)
                     || ((shadow_q[3] == 4'd2) && (shadow_q[2] > 4'd3))
                     || (shadow_q[1] > 4'd5);
      end
   end

endmodule

// File: tb/tb_ss_readback.sv
// Directed bench for ss_readback: scans digit patterns onto the bus and checks
// every cycle against a run-length/frame model plus literal expectations.
module tb_ss_readback;

   localparam int STABLE = 16;
   localparam int TMO    = 1000;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] an;
   logic [7:0] sg;
   logic [3:0] hours2, hours1, mins2, mins1;
   logic       frame_valid, decode_error, range_error, display_alive;

   always #5 clk = ~clk;

   ss_readback #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK100MHZ(clk),
      .ResetButton(rst),
      .SegmentDrivers(an),
      .SevenSegment(sg),
      .hours2(hours2),
      .hours1(hours1),
      .mins2(mins2),
      .mins1(mins1),
      .frame_valid(frame_valid),
      .decode_error(decode_error),
      .range_error(range_error),
      .display_alive(display_alive)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] enc(input int d);
      logic [6:0] c;
      case (d)
         0: c = 7'h40;  1: c = 7'h79;  2: c = 7'h24;  3: c = 7'h30;  4: c = 7'h19;
         5: c = 7'h12;  6: c = 7'h02;  7: c = 7'h78;  8: c = 7'h00;  default: c = 7'h10;
      endcase
      return {1'b1, c};
   endfunction

   function automatic int dec(input logic [6:0] s);
      logic [7:0] e;
      for (int d = 0; d < 10; d++) begin
         e = enc(d);
         if (e[6:0] == s) return d;
      end
      return -1;
   endfunction

   // Registered sample as a key, -1 when the sample is not a legal digit scan.
   function automatic int key_of(input logic [7:0] a, input logic [7:0] s);
      logic [3:0] lo;
      lo = ~a[3:0];
      if (a[7:4] != 4'hF || $countones(lo) != 1 || s[6:0] == 7'h7F) return -1;
      return int'({a[3:0], s[6:0]});
   endfunction

   // Behavioural model
   int         hist[$];
   int         samp_prev;
   int         m_shadow[4];
   int         m_out[4];
   logic [3:0] m_seen;
   logic       m_fv, m_de, m_re, m_alive;
   int         since;

   task automatic model_step(input logic r, input logic [7:0] a, input logic [7:0] s);
      int  last, d, idx;
      bit  cap, legal_cap;
      logic [3:0] lo;
      if (r) begin
         hist.delete();
         for (int i = 0; i <= STABLE; i++) hist.push_back(-1);
         samp_prev = -1;
         for (int i = 0; i < 4; i++) begin m_shadow[i] = 0; m_out[i] = 0; end
         m_seen = 4'h0; m_fv = 0; m_de = 0; m_re = 0; m_alive = 0; since = 0;
         return;
      end
      hist.push_back(samp_prev);
      hist.pop_front();
      // A capture happens when exactly the last STABLE samples are one legal pattern.
      last = hist[STABLE];
      cap  = (last != -1) && (hist[0] != last);
      for (int i = 1; i < STABLE; i++) if (hist[i] != last) cap = 0;
      m_fv = 0; m_de = 0;
      if (m_seen == 4'hF) begin
         for (int i = 0; i < 4; i++) m_out[i] = m_shadow[i];
         m_fv   = 1;
         m_re   = (m_out[3] > 2) || (m_out[3] == 2 && m_out[2] > 3) || (m_out[1] > 5);
         m_seen = 4'h0;
      end
      legal_cap = 0;
      if (cap) begin
         d  = dec(7'(last));
         lo = ~4'(last >> 7);
         idx = 0;
         for (int i = 0; i < 4; i++) if (lo[i]) idx = i;
         if (d >= 0) begin
            m_shadow[idx] = d;
            m_seen[idx]   = 1'b1;
            since = 0; m_alive = 1; legal_cap = 1;
         end else begin
            m_de = 1;
         end
      end
      if (!legal_cap) begin
         since++;
         if (since >= TMO) begin m_alive = 0; m_seen = 4'h0; end
      end
      samp_prev = key_of(a, s);
   endtask

   int cyc = 0;
   int fv_cnt = 0, de_cnt = 0;
   int last_fv_cyc = -1, fall_cyc = -1;
   logic alive_prev = 1'b0;

   initial begin
      forever begin
         @(posedge clk);
         model_step(rst, an, sg);
         #1;
         cyc++;
         chk("digits", {16'h0, hours2, hours1, mins2, mins1},
             {16'h0, 4'(m_out[3]), 4'(m_out[2]), 4'(m_out[1]), 4'(m_out[0])});
         chk("frame_valid", 32'(frame_valid), 32'(m_fv));
         chk("decode_error", 32'(decode_error), 32'(m_de));
         chk("range_error", 32'(range_error), 32'(m_re));
         chk("display_alive", 32'(display_alive), 32'(m_alive));
         if (frame_valid === 1'b1) begin fv_cnt++; last_fv_cyc = cyc; end
         if (decode_error === 1'b1) de_cnt++;
         if (alive_prev === 1'b1 && display_alive === 1'b0) fall_cyc = cyc;
         alive_prev = display_alive;
      end
   end

   task automatic drive(input logic [7:0] a, input logic [7:0] s, input int n);
      an = a; sg = s;
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [7:0] anode(input int idx);
      logic [3:0] lo;
      lo = ~(4'b0001 << idx);
      return {4'hF, lo};
   endfunction

   task automatic digit(input int idx, input int d);
      drive(anode(idx), enc(d), 32);
      drive(8'hFF, 8'hFF, 4);
   endtask

   task automatic scan(input int h2, input int h1, input int m2, input int m1);
      digit(3, h2); digit(2, h1); digit(1, m2); digit(0, m1);
   endtask

   function automatic logic [15:0] outs();
      return {hours2, hours1, mins2, mins1};
   endfunction

   initial begin
      rst = 1'b1; an = 8'hFF; sg = 8'hFF;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      drive(8'hFF, 8'hFF, 4);

      fv_cnt = 0;
      scan(1, 2, 3, 4);
      chk("scan1234_frames", fv_cnt, 1);
      chk("scan1234_digits", outs(), 16'h1234);
      chk("scan1234_range", range_error, 0);
      chk("scan1234_alive", display_alive, 1);

      fv_cnt = 0; de_cnt = 0;
      digit(3, 1); digit(2, 2);
      drive(anode(0), enc(8), 10);
      drive(8'hFF, 8'hFF, 4);
      chk("glitch_hold", outs(), 16'h1234);
      digit(1, 3); digit(0, 4);
      chk("glitch_frames", fv_cnt, 1);
      chk("glitch_decerr", de_cnt, 0);
      chk("glitch_digits", outs(), 16'h1234);

      fv_cnt = 0; de_cnt = 0;
      digit(3, 1); digit(2, 2);
      drive(anode(1), 8'hFE, 32);
      drive(8'hFF, 8'hFF, 4);
      digit(0, 4);
      chk("bad_decerr", de_cnt, 1);
      chk("bad_noframe", fv_cnt, 0);
      digit(1, 3);
      chk("bad_frame_after_fix", fv_cnt, 1);

      scan(2, 7, 6, 1);
      chk("scan2761_digits", outs(), 16'h2761);
      chk("scan2761_range", range_error, 1);
      scan(2, 3, 5, 9);
      chk("scan2359_digits", outs(), 16'h2359);
      chk("scan2359_range", range_error, 0);

      scan(1, 2, 3, 4);
      fall_cyc = -1;
      drive(8'hFF, 8'hFF, 1100);
      chk("timeout_alive", display_alive, 0);
      chk("timeout_delay", fall_cyc - last_fv_cyc, TMO - 1);
      chk("timeout_digits", outs(), 16'h1234);

      digit(3, 1); digit(2, 2); digit(1, 3);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_digits", outs(), 16'h0000);
      chk("reset_flags", {frame_valid, decode_error, range_error, display_alive}, 4'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      fv_cnt = 0;
      scan(0, 8, 1, 5);
      chk("post_reset_frames", fv_cnt, 1);
      chk("post_reset_digits", outs(), 16'h0815);
      chk("post_reset_alive", display_alive, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
